gigatron_controller_tx: RTL

//  Transmit end of the Gigatron game-controller serial interface (4021-style).

---
 rtl/gigatron_ctl_pkg.sv | 14 +
 rtl/sync_edge_detect.sv | 31 +++
 rtl/gigatron_controller_tx.sv | 118 +++++++++++
 3 files changed

// File: rtl/gigatron_ctl_pkg.sv
// Shared types and defaults for the Gigatron game-controller transmit path.
package gigatron_ctl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } ctl_state_t;

   localparam int unsigned CTL_WIDTH_DEFAULT = 8;
   localparam logic        CTL_IDLE_FILL     = 1'b1;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer for one asynchronous host pin, with a history flop
// so edges are detected on the synchronized level.
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  =  sync_q[SYNC_STAGES-1] & ~hist_q;
   assign fall_o  = ~sync_q[SYNC_STAGES-1] &  hist_q;

endmodule

// File: rtl/gigatron_controller_tx.sv
// 4021-style controller transmitter: parallel-loads active-low buttons while the
// host latch is high, then shifts them out MSB-first on host shift-clock rises.
module gigatron_controller_tx
   import gigatron_ctl_pkg::*;
#(
   parameter int unsigned WIDTH       = CTL_WIDTH_DEFAULT,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        SERIAL_FILL = CTL_IDLE_FILL
) (
   input  logic             clock_50,
   input  logic             MR,
   input  logic [WIDTH-1:0] buttons_n,
   input  logic             ctl_latch,
   input  logic             ctl_clock,
   output logic             ctl_data,
   output logic             busy,
   output logic             frame_done
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

   logic latch_s, latch_rise, latch_fall;
   logic clk_level, clk_rise, clk_fall;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
      .clk_i   (clock_50),
      .rst_ni  (MR),
      .async_i (ctl_latch),
      .level_o (latch_s),
      .rise_o  (latch_rise),
      .fall_o  (latch_fall)
   );

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clock (
      .clk_i   (clock_50),
      .rst_ni  (MR),
      .async_i (ctl_clock),
      .level_o (clk_level),
      .rise_o  (clk_rise),
      .fall_o  (clk_fall)
   );

   logic unused_edges;
   assign unused_edges = latch_rise ^ clk_level ^ clk_fall;

   ctl_state_t       state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             shift_en;

   always_comb begin
      state_d  = state_q;
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      shift_en = 1'b0;

      // A high latch overrides everything, including a shift in the same cycle.
      if (latch_s) begin
         state_d = LOAD;
         sreg_d  = buttons_n;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            LOAD: begin
               if (latch_fall) begin
                  state_d = SHIFT;
                  cnt_d   = '0;
               end
            end
            SHIFT: begin
               if (clk_rise) begin
                  shift_en = 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: shift_en = clk_rise;
         endcase

         if (shift_en) begin
            sreg_d = {sreg_q[WIDTH-2:0], SERIAL_FILL};
            if (cnt_q != CNT_FULL) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      busy_d = (state_d == SHIFT);
   end

   always_ff @(posedge clock_50 or negedge MR) begin
      if (!MR) begin
         state_q <= IDLE;
         sreg_q  <= '1;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign ctl_data   = sreg_q[WIDTH-1];
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule
